// File: rtl/cook_timer_ctrl.sv
// Microwave cook-time controller: keypad entry of an M:SS BCD time, start/pause/done FSM, 1 Hz countdown.
// Optional feature macro COOK_ADD30_EN: start while cooking adds 30 s (saturating at 9:59).
module cook_timer_ctrl #(
  parameter int TICK_DIV = 100
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop_clr,
  input  logic       door_open,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic       mag_on,
  output logic       done,
  output logic [2:0] state
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef struct packed {
    logic [3:0] mo;
    logic [3:0] st;
    logic [3:0] so;
  } ctime_t;

  localparam ctime_t TIME_ZERO   = '{mo: 4'd0, st: 4'd0, so: 4'd0};
  localparam ctime_t TIME_THIRTY = '{mo: 4'd0, st: 4'd3, so: 4'd0};

  state_e         state_q, state_d;
  ctime_t         time_q, time_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic           mag_on_q, mag_on_d;
  logic           done_q, done_d;

  logic           key_ok;
  ctime_t         time_shift;
  ctime_t         cook_base;
  ctime_t         cook_dec;

  function automatic ctime_t bcd_dec(input ctime_t t);
    ctime_t r;
    r = t;
    if (t.so != 4'd0) begin
      r.so = t.so - 4'd1;
    end else begin
      r.so = 4'd9;
      if (t.st != 4'd0) begin
        r.st = t.st - 4'd1;
      end else begin
        r.st = 4'd5;
        r.mo = t.mo - 4'd1;
      end
    end
    return r;
  endfunction

`ifdef COOK_ADD30_EN
  function automatic ctime_t bcd_add30(input ctime_t t);
    ctime_t r;
    logic [3:0] tens;
    r    = t;
    tens = t.st + 4'd3;
    if (tens >= 4'd6) begin
      if (t.mo == 4'd9) begin
        r = '{mo: 4'd9, st: 4'd5, so: 4'd9};
      end else begin
        r.st = tens - 4'd6;
        r.mo = t.mo + 4'd1;
      end
    end else begin
      r.st = tens;
    end
    return r;
  endfunction
`endif

  assign key_ok     = key_valid && (key_digit <= 4'd9);
  assign time_shift = '{mo: time_q.st, st: time_q.so, so: key_digit};

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    time_d    = time_q;
    presc_d   = presc_q;
    cook_base = time_q;
    cook_dec  = bcd_dec(time_q);

    // Only the highest-priority active event acts: stop_clr > door_open > start > key.
    unique case (state_q)
      ST_IDLE: begin
        if (stop_clr) begin
          time_d = TIME_ZERO;
        end else if (door_open) begin
          state_d = state_q;
        end else if (start) begin
          time_d  = TIME_THIRTY;
          presc_d = '0;
          state_d = ST_COOK;
        end else if (key_ok) begin
          time_d  = time_shift;
          state_d = ST_SET;
        end
      end

      ST_SET: begin
        if (stop_clr) begin
          time_d  = TIME_ZERO;
          state_d = ST_IDLE;
        end else if (door_open) begin
          state_d = state_q;
        end else if (start) begin
          if (time_q != TIME_ZERO) begin
            presc_d = '0;
            state_d = ST_COOK;
          end
        end else if (key_ok && (time_q.so <= 4'd5)) begin
          time_d = time_shift;
        end
      end

      ST_COOK: begin
        if (stop_clr || door_open) begin
          state_d = ST_PAUSE;
        end else begin
`ifdef COOK_ADD30_EN
          if (start) cook_base = bcd_add30(time_q);
`endif
          // An add-30 and a tick in the same cycle both take effect.
          cook_dec = bcd_dec(cook_base);
          if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            time_d  = cook_dec;
            if (cook_dec == TIME_ZERO) state_d = ST_DONE;
          end else begin
            presc_d = presc_q + PW'(1);
            time_d  = cook_base;
          end
        end
      end

      ST_PAUSE: begin
        if (stop_clr) begin
          time_d  = TIME_ZERO;
          presc_d = '0;
          state_d = ST_IDLE;
        end else if (door_open) begin
          state_d = state_q;
        end else if (start) begin
          state_d = ST_COOK;
        end
      end

      ST_DONE: begin
        if (stop_clr || door_open) state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        time_d  = TIME_ZERO;
        presc_d = '0;
      end
    endcase

    mag_on_d = (state_d == ST_COOK);
    done_d   = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q  <= ST_IDLE;
      time_q   <= TIME_ZERO;
      presc_q  <= '0;
      mag_on_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      time_q   <= time_d;
      presc_q  <= presc_d;
      mag_on_q <= mag_on_d;
      done_q   <= done_d;
    end
  end

  assign sec_ones = time_q.so;
  assign sec_tens = time_q.st;
  assign min_ones = time_q.mo;
  assign mag_on   = mag_on_q;
  assign done     = done_q;
  assign state    = state_q;

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Self-checking bench for cook_timer_ctrl (TICK_DIV=4): vector table plus multi-cycle sequences.
module tb_cook_timer_ctrl;

  localparam int TD = 4;
  localparam logic [2:0] S_IDLE = 3'd0, S_SET = 3'd1, S_COOK = 3'd2, S_PAUSE = 3'd3, S_DONE = 3'd4;
`ifdef COOK_ADD30_EN
  localparam bit ADD30 = 1'b1;
`else
  localparam bit ADD30 = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clrn = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       start = 1'b0;
  logic       stop_clr = 1'b0;
  logic       door_open = 1'b0;
  logic [3:0] sec_ones, sec_tens, min_ones;
  logic       mag_on, done;
  logic [2:0] state;

  always #5 clk = ~clk;

  cook_timer_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .clrn(clrn), .key_valid(key_valid), .key_digit(key_digit),
    .start(start), .stop_clr(stop_clr), .door_open(door_open),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones),
    .mag_on(mag_on), .done(done), .state(state)
  );

  typedef struct {
    logic       kv;
    logic [3:0] kd;
    logic       st;
    logic       sc;
    logic       dr;
    logic [2:0] es;
    int         secs;
    logic       mag;
    logic       dn;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t sb[$];
  vec_t tbl[18];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [11:0] digs(input int s);
    logic [3:0] m, t, o;
    m = 4'(s / 60);
    t = 4'((s % 60) / 10);
    o = 4'(s % 10);
    return {m, t, o};
  endfunction

  function automatic vec_t mk(input logic kv, input logic [3:0] kd, input logic st, input logic sc,
                              input logic dr, input logic [2:0] es, input int secs,
                              input logic mag, input logic dn);
    vec_t v;
    v.kv = kv; v.kd = kd; v.st = st; v.sc = sc; v.dr = dr;
    v.es = es; v.secs = secs; v.mag = mag; v.dn = dn;
    return v;
  endfunction

  task automatic check_outs(input string tag, input logic [2:0] es, input int secs,
                            input logic mag, input logic dn);
    check($sformatf("%s state", tag), 32'(state), 32'(es));
    check($sformatf("%s time", tag), 32'({min_ones, sec_tens, sec_ones}), 32'(digs(secs)));
    check($sformatf("%s mag_on", tag), 32'(mag_on), 32'(mag));
    check($sformatf("%s done", tag), 32'(done), 32'(dn));
  endtask

  // Drive one cycle of inputs, queue its expectation, then compare after the edge.
  task automatic step(input vec_t v, input string tag);
    vec_t e;
    key_valid = v.kv; key_digit = v.kd; start = v.st; stop_clr = v.sc; door_open = v.dr;
    sb.push_back(v);
    @(posedge clk);
    #1;
    key_valid = 1'b0; start = 1'b0; stop_clr = 1'b0;
    e = sb.pop_front();
    check_outs(tag, e.es, e.secs, e.mag, e.dn);
  endtask

  task automatic run(input logic kv, input logic [3:0] kd, input logic st, input logic sc,
                     input logic dr, input logic [2:0] es, input int secs,
                     input logic mag, input logic dn, input string tag);
    step(mk(kv, kd, st, sc, dr, es, secs, mag, dn), tag);
  endtask

  initial begin
    int secs;
    logic s;

    #1 clrn = 1'b0;
    #3;
    check_outs("reset", S_IDLE, 0, 1'b0, 1'b0);
    #8 clrn = 1'b1;
    @(posedge clk);
    #1;
    check_outs("post_reset", S_IDLE, 0, 1'b0, 1'b0);

    tbl[0]  = mk(1, 4'd1,  0, 0, 0, S_SET,   1,  0, 0);
    tbl[1]  = mk(1, 4'd2,  0, 0, 0, S_SET,   12, 0, 0);
    tbl[2]  = mk(1, 4'd3,  0, 0, 0, S_SET,   83, 0, 0);
    tbl[3]  = mk(1, 4'd12, 0, 0, 0, S_SET,   83, 0, 0);
    tbl[4]  = mk(0, 4'd0,  1, 0, 1, S_SET,   83, 0, 0);
    tbl[5]  = mk(0, 4'd0,  1, 0, 0, S_COOK,  83, 1, 0);
    tbl[6]  = mk(0, 4'd0,  0, 1, 0, S_PAUSE, 83, 0, 0);
    tbl[7]  = mk(1, 4'd5,  0, 0, 0, S_PAUSE, 83, 0, 0);
    tbl[8]  = mk(0, 4'd0,  0, 1, 0, S_IDLE,  0,  0, 0);
    tbl[9]  = mk(1, 4'd9,  0, 0, 0, S_SET,   9,  0, 0);
    tbl[10] = mk(1, 4'd4,  0, 0, 0, S_SET,   9,  0, 0);
    tbl[11] = mk(0, 4'd0,  0, 1, 0, S_IDLE,  0,  0, 0);
    tbl[12] = mk(1, 4'd0,  0, 0, 0, S_SET,   0,  0, 0);
    tbl[13] = mk(0, 4'd0,  1, 0, 0, S_SET,   0,  0, 0);
    tbl[14] = mk(0, 4'd0,  0, 1, 0, S_IDLE,  0,  0, 0);
    tbl[15] = mk(1, 4'd7,  1, 0, 0, S_COOK,  30, 1, 0);
    tbl[16] = mk(0, 4'd0,  0, 0, 1, S_PAUSE, 30, 0, 0);
    tbl[17] = mk(0, 4'd0,  0, 1, 0, S_IDLE,  0,  0, 0);
    for (int i = 0; i < 18; i++) step(tbl[i], $sformatf("vec%0d", i));

    // 0:03 countdown: done pulse exactly 3*TD cycles after COOK entry.
    run(1, 4'd3, 0, 0, 0, S_SET, 3, 0, 0, "done_key");
    run(0, 4'd0, 1, 0, 0, S_COOK, 3, 1, 0, "done_start");
    for (int k = 1; k <= 3 * TD + 1; k++) begin
      if (k >= 3 * TD) run(0, 4'd0, 0, 0, 0, S_DONE, 0, 0, k == 3 * TD, $sformatf("done_k%0d", k));
      else             run(0, 4'd0, 0, 0, 0, S_COOK, 3 - k / TD, 1, 0, $sformatf("done_k%0d", k));
    end
    run(0, 4'd0, 1, 0, 0, S_DONE, 0, 0, 0, "done_ign_start");
    run(1, 4'd5, 0, 0, 0, S_DONE, 0, 0, 0, "done_ign_key");
    run(0, 4'd0, 0, 1, 0, S_IDLE, 0, 0, 0, "done_clr");

    // 1:00 countdown through the borrow chain down to 0:08.
    run(1, 4'd1, 0, 0, 0, S_SET, 1, 0, 0, "brw_k1");
    run(1, 4'd0, 0, 0, 0, S_SET, 10, 0, 0, "brw_k2");
    run(1, 4'd0, 0, 0, 0, S_SET, 60, 0, 0, "brw_k3");
    run(0, 4'd0, 1, 0, 0, S_COOK, 60, 1, 0, "brw_start");
    for (int k = 1; k <= 52 * TD; k++)
      run(0, 4'd0, 0, 0, 0, S_COOK, 60 - k / TD, 1, 0, $sformatf("brw_k%0d", k));
    run(0, 4'd0, 0, 1, 0, S_PAUSE, 8, 0, 0, "brw_pause");
    run(0, 4'd0, 0, 1, 0, S_IDLE, 0, 0, 0, "brw_clr");

    // Door pause with prescaler at 2, then resume.
    run(1, 4'd5, 0, 0, 0, S_SET, 5, 0, 0, "pse_key");
    run(0, 4'd0, 1, 0, 0, S_COOK, 5, 1, 0, "pse_start");
    run(0, 4'd0, 0, 0, 0, S_COOK, 5, 1, 0, "pse_p1");
    run(0, 4'd0, 0, 0, 0, S_COOK, 5, 1, 0, "pse_p2");
    run(0, 4'd0, 0, 0, 1, S_PAUSE, 5, 0, 0, "pse_door");
    run(0, 4'd0, 0, 0, 1, S_PAUSE, 5, 0, 0, "pse_hold1");
    run(0, 4'd0, 0, 0, 1, S_PAUSE, 5, 0, 0, "pse_hold2");
    run(0, 4'd0, 1, 0, 1, S_PAUSE, 5, 0, 0, "pse_start_open");
    run(0, 4'd0, 1, 0, 0, S_COOK, 5, 1, 0, "pse_resume");
    run(0, 4'd0, 0, 0, 0, S_COOK, 5, 1, 0, "pse_r1");
    run(0, 4'd0, 0, 0, 0, S_COOK, 4, 1, 0, "pse_r2");
    secs = ADD30 ? 34 : 4;
    run(0, 4'd0, 1, 0, 0, S_COOK, secs, 1, 0, "cook_start");
    run(0, 4'd0, 0, 0, 0, S_COOK, secs, 1, 0, "cook_s1");
    run(0, 4'd0, 0, 0, 0, S_COOK, secs, 1, 0, "cook_s2");
    run(0, 4'd0, 0, 0, 0, S_COOK, secs - 1, 1, 0, "cook_s3");
    run(0, 4'd0, 0, 1, 0, S_PAUSE, secs - 1, 0, 0, "cook_stop");
    run(0, 4'd0, 0, 1, 0, S_IDLE, 0, 0, 0, "cook_clr");

    // 0:45 + start.
    run(1, 4'd4, 0, 0, 0, S_SET, 4, 0, 0, "a45_k1");
    run(1, 4'd5, 0, 0, 0, S_SET, 45, 0, 0, "a45_k2");
    run(0, 4'd0, 1, 0, 0, S_COOK, 45, 1, 0, "a45_start");
    run(0, 4'd0, 1, 0, 0, S_COOK, ADD30 ? 75 : 45, 1, 0, "a45_add");
    run(0, 4'd0, 0, 1, 0, S_PAUSE, ADD30 ? 75 : 45, 0, 0, "a45_stop");
    run(0, 4'd0, 0, 1, 0, S_IDLE, 0, 0, 0, "a45_clr");

    // 5:15 with repeated start, avoiding tick cycles; saturates at 9:59 when enabled.
    run(1, 4'd5, 0, 0, 0, S_SET, 5, 0, 0, "sat_k1");
    run(1, 4'd1, 0, 0, 0, S_SET, 51, 0, 0, "sat_k2");
    run(1, 4'd5, 0, 0, 0, S_SET, 315, 0, 0, "sat_k3");
    run(0, 4'd0, 1, 0, 0, S_COOK, 315, 1, 0, "sat_start");
    secs = 315;
    for (int k = 1; k <= 16; k++) begin
      s = (k % TD) != 0;
      if (ADD30 && s) secs = (secs + 30 > 599) ? 599 : secs + 30;
      if ((k % TD) == 0) secs = secs - 1;
      run(0, 4'd0, s, 0, 0, S_COOK, secs, 1, 0, $sformatf("sat_k%0d", k));
    end
    run(0, 4'd0, 0, 1, 0, S_PAUSE, secs, 0, 0, "sat_stop");
    run(0, 4'd0, 0, 1, 0, S_IDLE, 0, 0, 0, "sat_clr");

    // Asynchronous reset in the middle of COOK.
    run(1, 4'd2, 0, 0, 0, S_SET, 2, 0, 0, "ar_key");
    run(0, 4'd0, 1, 0, 0, S_COOK, 2, 1, 0, "ar_start");
    run(0, 4'd0, 0, 0, 0, S_COOK, 2, 1, 0, "ar_c1");
    #2 clrn = 1'b0;
    #1;
    check_outs("ar_async", S_IDLE, 0, 1'b0, 1'b0);
    @(negedge clk);
    clrn = 1'b1;
    @(posedge clk);
    #1;
    check_outs("ar_after", S_IDLE, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
